// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bundle: MEM-stage results in, register-file write port and status out.
interface mem_wb_stage_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned LT_W   = 3;

    logic              stall_i;
    logic              flush_i;
    logic              mem_valid_i;
    logic              mem_reg_wr_i;
    logic              mem_to_reg_i;
    logic              mem_link_i;
    logic [LT_W-1:0]   mem_load_type_i;
    logic [REG_AW-1:0] mem_rw_i;
    logic [XLEN-1:0]   mem_alu_out_i;
    logic [XLEN-1:0]   mem_rd_data_i;
    logic [XLEN-1:0]   mem_pc_plus4_i;

    logic [XLEN-1:0]   bus_w_o;
    logic [REG_AW-1:0] rw_o;
    logic              reg_wr_o;
    logic              wb_valid_o;
    logic [XLEN-1:0]   fwd_data_o;
    logic [XLEN-1:0]   retire_count_o;

    modport master (
        output stall_i, flush_i, mem_valid_i, mem_reg_wr_i, mem_to_reg_i, mem_link_i,
               mem_load_type_i, mem_rw_i, mem_alu_out_i, mem_rd_data_i, mem_pc_plus4_i,
        input  bus_w_o, rw_o, reg_wr_o, wb_valid_o, fwd_data_o, retire_count_o
    );

    modport slave (
        input  stall_i, flush_i, mem_valid_i, mem_reg_wr_i, mem_to_reg_i, mem_link_i,
               mem_load_type_i, mem_rw_i, mem_alu_out_i, mem_rd_data_i, mem_pc_plus4_i,
        output bus_w_o, rw_o, reg_wr_o, wb_valid_o, fwd_data_o, retire_count_o
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: big-endian load extraction, link/ALU/load select,
// register-file write port, forwarding copy and retire counter. All outputs registered.
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC_LINK = 32'h0,
    parameter logic [31:0] RETIRE_RESET  = 32'h0
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.slave  wb
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;
    localparam logic [REG_AW-1:0] LINK_REG = REG_AW'(31);

    logic [XLEN-1:0]   bus_w_q,    bus_w_d;
    logic [REG_AW-1:0] rw_q,       rw_d;
    logic              reg_wr_q,   reg_wr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   retire_q,   retire_d;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   link_data;
    logic [XLEN-1:0]   sel_data;
    logic [REG_AW-1:0] sel_rw;
    logic              sel_wr;

    // Big-endian lane extraction from the aligned read word.
    always_comb begin
        byte_sel = 8'h00;
        case (wb.mem_alu_out_i[1:0])
            2'd0:    byte_sel = wb.mem_rd_data_i[31:24];
            2'd1:    byte_sel = wb.mem_rd_data_i[23:16];
            2'd2:    byte_sel = wb.mem_rd_data_i[15:8];
            default: byte_sel = wb.mem_rd_data_i[7:0];
        endcase
        half_sel = wb.mem_alu_out_i[1] ? wb.mem_rd_data_i[15:0] : wb.mem_rd_data_i[31:16];

        load_data = wb.mem_rd_data_i;
        case (wb.mem_load_type_i)
            LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  load_data = {24'h0, byte_sel};
            LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  load_data = {16'h0, half_sel};
            default: load_data = wb.mem_rd_data_i;
        endcase
    end

    // Write-back select; link wins over load/ALU and forces $31.
    always_comb begin
        link_data = wb.mem_pc_plus4_i + XLEN'(4);
        if (wb.mem_link_i) begin
            sel_data = link_data;
            sel_rw   = LINK_REG;
        end else begin
            sel_data = wb.mem_to_reg_i ? load_data : wb.mem_alu_out_i;
            sel_rw   = wb.mem_rw_i;
        end
        sel_wr = wb.mem_valid_i & (wb.mem_reg_wr_i | wb.mem_link_i) & (sel_rw != '0);
    end

    // Next state: flush beats stall beats capture.
    always_comb begin
        bus_w_d    = bus_w_q;
        rw_d       = rw_q;
        reg_wr_d   = reg_wr_q;
        wb_valid_d = wb_valid_q;
        retire_d   = retire_q;
        if (wb.flush_i) begin
            reg_wr_d   = 1'b0;
            wb_valid_d = 1'b0;
        end else if (!wb.stall_i) begin
            bus_w_d    = sel_data;
            rw_d       = sel_rw;
            reg_wr_d   = sel_wr;
            wb_valid_d = wb.mem_valid_i;
            if (wb.mem_valid_i) begin
                retire_d = retire_q + XLEN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_w_q    <= RESET_PC_LINK;
            rw_q       <= '0;
            reg_wr_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            retire_q   <= RETIRE_RESET;
        end else begin
            bus_w_q    <= bus_w_d;
            rw_q       <= rw_d;
            reg_wr_q   <= reg_wr_d;
            wb_valid_q <= wb_valid_d;
            retire_q   <= retire_d;
        end
    end

    assign wb.bus_w_o        = bus_w_q;
    assign wb.fwd_data_o     = bus_w_q;
    assign wb.rw_o           = rw_q;
    assign wb.reg_wr_o       = reg_wr_q;
    assign wb.wb_valid_o     = wb_valid_q;
    assign wb.retire_count_o = retire_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table plus stall/flush/reset/wrap sequences.
module tb_mem_wb_stage;
    logic clk;
    logic rst_n;

    mem_wb_stage_if m_if ();
    mem_wb_stage_if w_if ();

    mem_wb_stage dut (.clk(clk), .rst_n(rst_n), .wb(m_if));
    mem_wb_stage #(.RESET_PC_LINK(32'hA5A5_0000), .RETIRE_RESET(32'hFFFF_FFFE))
        dut_w (.clk(clk), .rst_n(rst_n), .wb(w_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, valid, regwr, toreg, link;
        logic [2:0]  lt;
        logic [4:0]  rw;
        logic [31:0] alu, rd, pc;
        logic [31:0] e_busw;
        logic [4:0]  e_rw;
        logic        e_wr, e_wbv;
        logic        chk_data;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] busw;
        logic [4:0]  rw;
        logic        wr, wbv;
        logic [31:0] ret;
        logic        chk_data;
        string       name;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] model_ret = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic stall, input logic flush, input logic valid,
                                input logic regwr, input logic toreg, input logic link,
                                input logic [2:0] lt, input logic [4:0] rw,
                                input logic [31:0] alu, input logic [31:0] rd,
                                input logic [31:0] pc, input logic [31:0] e_busw,
                                input logic [4:0] e_rw, input logic e_wr, input logic e_wbv,
                                input logic chk_data, input string name);
        vec_t v;
        v.stall = stall; v.flush = flush; v.valid = valid; v.regwr = regwr;
        v.toreg = toreg; v.link = link; v.lt = lt; v.rw = rw;
        v.alu = alu; v.rd = rd; v.pc = pc;
        v.e_busw = e_busw; v.e_rw = e_rw; v.e_wr = e_wr; v.e_wbv = e_wbv;
        v.chk_data = chk_data; v.name = name;
        return v;
    endfunction

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (e.chk_data) begin
            check({e.name, ".busw"}, m_if.bus_w_o, e.busw);
            check({e.name, ".fwd"},  m_if.fwd_data_o, e.busw);
            check({e.name, ".rw"},   32'(m_if.rw_o), 32'(e.rw));
        end
        check({e.name, ".regwr"},  32'(m_if.reg_wr_o), 32'(e.wr));
        check({e.name, ".wbvalid"}, 32'(m_if.wb_valid_o), 32'(e.wbv));
        check({e.name, ".retire"}, m_if.retire_count_o, e.ret);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        m_if.stall_i = v.stall;   m_if.flush_i = v.flush;
        m_if.mem_valid_i = v.valid; m_if.mem_reg_wr_i = v.regwr;
        m_if.mem_to_reg_i = v.toreg; m_if.mem_link_i = v.link;
        m_if.mem_load_type_i = v.lt; m_if.mem_rw_i = v.rw;
        m_if.mem_alu_out_i = v.alu; m_if.mem_rd_data_i = v.rd;
        m_if.mem_pc_plus4_i = v.pc;
        if (!v.flush && !v.stall && v.valid) model_ret = model_ret + 32'd1;
        e.busw = v.e_busw; e.rw = v.e_rw; e.wr = v.e_wr; e.wbv = v.e_wbv;
        e.ret = model_ret; e.chk_data = v.chk_data; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic idle_inputs();
        m_if.stall_i = 1'b0; m_if.flush_i = 1'b0; m_if.mem_valid_i = 1'b0;
        m_if.mem_reg_wr_i = 1'b0; m_if.mem_to_reg_i = 1'b0; m_if.mem_link_i = 1'b0;
        m_if.mem_load_type_i = 3'd0; m_if.mem_rw_i = 5'd0; m_if.mem_alu_out_i = 32'h0;
        m_if.mem_rd_data_i = 32'h0; m_if.mem_pc_plus4_i = 32'h0;
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        w_if.stall_i = 1'b0; w_if.flush_i = 1'b0; w_if.mem_valid_i = 1'b0;
        w_if.mem_reg_wr_i = 1'b1; w_if.mem_to_reg_i = 1'b0; w_if.mem_link_i = 1'b0;
        w_if.mem_load_type_i = 3'd0; w_if.mem_rw_i = 5'd1; w_if.mem_alu_out_i = 32'h0;
        w_if.mem_rd_data_i = 32'h0; w_if.mem_pc_plus4_i = 32'h0;

        // stall flush valid regwr toreg link lt rw alu rd pc | busw rw wr wbv chk
        tbl.push_back(mk(0,0,1,1,0,0,3'd0,5'd5, 32'h1234_5678,RD,32'h0, 32'h1234_5678,5'd5,1,1,1,"alu"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd1,5'd3, 32'h0000_0100,RD,32'h0, 32'hFFFF_FF80,5'd3,1,1,1,"lb00"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd2,5'd4, 32'h0000_0100,RD,32'h0, 32'h0000_0080,5'd4,1,1,1,"lbu00"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd1,5'd4, 32'h0000_0103,RD,32'h0, 32'h0000_0001,5'd4,1,1,1,"lb11"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd1,5'd4, 32'h0000_0101,RD,32'h0, 32'hFFFF_FFFF,5'd4,1,1,1,"lb01"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd2,5'd4, 32'h0000_0102,RD,32'h0, 32'h0000_007F,5'd4,1,1,1,"lbu10"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd3,5'd8, 32'h0000_0102,RD,32'h0, 32'h0000_7F01,5'd8,1,1,1,"lh10"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd3,5'd8, 32'h0000_0100,RD,32'h0, 32'hFFFF_80FF,5'd8,1,1,1,"lh00"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd4,5'd8, 32'h0000_0100,RD,32'h0, 32'h0000_80FF,5'd8,1,1,1,"lhu00"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd4,5'd8, 32'h0000_0101,RD,32'h0, 32'h0000_80FF,5'd8,1,1,1,"lhu01"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd0,5'd9, 32'h0000_0103,RD,32'h0, RD,5'd9,1,1,1,"lw11"));
        tbl.push_back(mk(0,0,1,1,1,0,3'd7,5'd9, 32'h0000_0102,RD,32'h0, RD,5'd9,1,1,1,"lt7"));
        tbl.push_back(mk(0,0,1,0,1,1,3'd1,5'd7, 32'h0000_0100,RD,32'h0040_0010, 32'h0040_0014,5'd31,1,1,1,"link"));
        tbl.push_back(mk(0,0,1,1,0,1,3'd0,5'd0, 32'h1111_1111,RD,32'hFFFF_FFFC, 32'h0,5'd31,1,1,1,"linkwrap"));
        tbl.push_back(mk(0,0,1,1,0,0,3'd0,5'd0, 32'h0BAD_F00D,RD,32'h0, 32'h0BAD_F00D,5'd0,0,1,1,"r0"));
        tbl.push_back(mk(0,0,0,1,0,0,3'd0,5'd5, 32'h0000_AAAA,RD,32'h0, 32'h0000_AAAA,5'd5,0,0,1,"invalid"));
        tbl.push_back(mk(0,0,1,0,0,0,3'd0,5'd6, 32'h0000_5555,RD,32'h0, 32'h0000_5555,5'd6,0,1,1,"noregwr"));
        // multi-cycle hold / bubble sequence
        tbl.push_back(mk(0,0,1,1,0,0,3'd0,5'd9, 32'hDEAD_BEEF,RD,32'h0, 32'hDEAD_BEEF,5'd9,1,1,1,"pre_stall"));
        tbl.push_back(mk(1,0,1,1,0,0,3'd0,5'd10,32'h0000_1111,RD,32'h0, 32'hDEAD_BEEF,5'd9,1,1,1,"stall1"));
        tbl.push_back(mk(1,0,0,0,1,1,3'd1,5'd11,32'h0000_2222,RD,32'h0, 32'hDEAD_BEEF,5'd9,1,1,1,"stall2"));
        tbl.push_back(mk(1,1,1,1,0,0,3'd0,5'd12,32'h0000_3333,RD,32'h0, 32'h0,5'd0,0,0,0,"flush_stall"));
        tbl.push_back(mk(0,0,1,1,0,0,3'd0,5'd2, 32'h0000_0005,RD,32'h0, 32'h0000_0005,5'd2,1,1,1,"post_flush"));
        tbl.push_back(mk(0,1,1,1,0,0,3'd0,5'd13,32'h0000_4444,RD,32'h0, 32'h0,5'd0,0,0,0,"flush"));

        // power-on reset values
        #12;
        check("rst.busw",    m_if.bus_w_o, 32'h0);
        check("rst.rw",      32'(m_if.rw_o), 32'h0);
        check("rst.regwr",   32'(m_if.reg_wr_o), 32'h0);
        check("rst.wbvalid", 32'(m_if.wb_valid_o), 32'h0);
        check("rst.retire",  m_if.retire_count_o, 32'h0);
        check("rst.w_busw",  w_if.bus_w_o, 32'hA5A5_0000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // asynchronous reset mid-cycle, away from any edge
        apply(mk(0,0,1,1,0,0,3'd0,5'd14,32'h0000_7777,RD,32'h0, 32'h0000_7777,5'd14,1,1,1,"pre_rst"));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.regwr",   32'(m_if.reg_wr_o), 32'h0);
        check("arst.wbvalid", 32'(m_if.wb_valid_o), 32'h0);
        check("arst.retire",  m_if.retire_count_o, 32'h0);
        check("arst.busw",    m_if.bus_w_o, 32'h0);
        model_ret = 32'h0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0,0,1,1,0,0,3'd0,5'd15,32'h0000_8888,RD,32'h0, 32'h0000_8888,5'd15,1,1,1,"post_rst"));

        // retire counter wrap on the preset instance
        check("wrap.start", w_if.retire_count_o, 32'hFFFF_FFFE);
        @(negedge clk); w_if.mem_valid_i = 1'b1;
        @(posedge clk); #1;
        check("wrap.max", w_if.retire_count_o, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("wrap.zero", w_if.retire_count_o, 32'h0);
        check("wrap.regwr", 32'(w_if.reg_wr_o), 32'h1);
        @(negedge clk); w_if.mem_valid_i = 1'b0;
        @(posedge clk); #1;
        check("wrap.hold", w_if.retire_count_o, 32'h0);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
